m14k_dcache_fill_writer: RTL and testbench

//  Write-side sequencer for the cache data array: takes a line-fill request (set, way) plus a

---
 rtl/m14k_fill_pkg.sv | 19 +
 rtl/m14k_fill_skid_buf.sv | 54 +++++
 rtl/m14k_dcache_fill_writer.sv | 156 +++++++++++++++
 tb/tb_m14k_dcache_fill_writer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m14k_fill_pkg.sv
// Shared types and constants for the D-cache line-fill writer.
package m14k_fill_pkg;

    localparam int WORDS_PER_LINE = 4;
    localparam int WORD_IDX_SIZE  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CMPL   = 2'd2
    } fill_state_t;

    // Keeps only the lowest set bit, so a malformed way select still
    // produces a single write column.
    function automatic logic [7:0] lowest_bit8(input logic [7:0] x);
        return x & (~x + 8'd1);
    endfunction

endpackage

// File: rtl/m14k_fill_skid_buf.sv
// Two-entry FIFO holding {fd_err, fd_data} refill words between the bus
// unit and the data-RAM write port. Push is ignored when full and pop is
// ignored when empty. Storage is not reset; only the pointers and count are.
module m14k_fill_skid_buf #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             greset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Data storage: written on accepted push only.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/m14k_dcache_fill_writer.sv
// Line-fill write sequencer for the D-cache data array.
// Accepts a fill request (set, one-hot way), then writes each buffered refill
// word into row {set, word} with a byte mask covering only the target way's
// column. A one-cycle fill_done (with fill_err) follows the fourth write.
//
// Build option: define M14K_FILL_CRITWORD_EN to start the fill at req_crit
// and wrap mod 4; otherwise the fill always runs words 0,1,2,3.
//
//   state  | meaning
//   IDLE   | waiting for a fill request, req_ready high
//   ACTIVE | draining buffered refill words into the RAM as grants allow
//   CMPL   | one cycle: fill_done/fill_err presented
module m14k_dcache_fill_writer
    import m14k_fill_pkg::*;
#(
    parameter int ASSOC          = 2,
    parameter int LINE_IDX_SIZE  = 10,
    parameter int WORD_WIDTH     = 32,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                  clk,
    input  logic                                  greset,
    input  logic                                  req_valid,
    output logic                                  req_ready,
    input  logic [LINE_IDX_SIZE-WORD_IDX_SIZE-1:0] req_set,
    input  logic [ASSOC-1:0]                      req_way,
    input  logic [WORD_IDX_SIZE-1:0]              req_crit,
    input  logic                                  fd_valid,
    output logic                                  fd_ready,
    input  logic [WORD_WIDTH-1:0]                 fd_data,
    input  logic                                  fd_err,
    input  logic                                  ram_gnt,
    output logic [LINE_IDX_SIZE-1:0]              ram_line_idx,
    output logic [BYTES_PER_WORD*ASSOC-1:0]       ram_wr_mask,
    output logic                                  ram_wr_str,
    output logic [WORD_WIDTH-1:0]                 ram_wr_data,
    output logic                                  fill_busy,
    output logic                                  fill_done,
    output logic                                  fill_err
);

    localparam int SET_W = LINE_IDX_SIZE - WORD_IDX_SIZE;
    localparam logic [WORD_IDX_SIZE-1:0] LAST_CNT = WORD_IDX_SIZE'(WORDS_PER_LINE - 1);

`ifdef M14K_FILL_CRITWORD_EN
    localparam bit CRIT_EN = 1'b1;
`else
    localparam bit CRIT_EN = 1'b0;
`endif

    fill_state_t                state;
    logic [SET_W-1:0]           set_q;
    logic [ASSOC-1:0]           way_q;
    logic [WORD_IDX_SIZE-1:0]   word_q;
    logic [WORD_IDX_SIZE-1:0]   cnt_q;
    logic                       err_q;

    logic [WORD_IDX_SIZE-1:0]   start_word;
    logic [ASSOC-1:0]           way_sel;
    logic [7:0]                 way_pad;

    logic [WORD_WIDTH:0]        buf_head;
    logic [1:0]                 buf_count;
    logic                       buf_full;
    logic                       buf_empty;
    logic                       buf_push;
    logic                       wr_fire;
    logic                       head_err;
    logic [WORD_WIDTH-1:0]      head_data;

    assign start_word = CRIT_EN ? req_crit : '0;
    assign way_pad    = lowest_bit8(8'(req_way));
    assign way_sel    = way_pad[ASSOC-1:0];

    assign buf_push  = fd_valid & ~buf_full;
    assign wr_fire   = (state == ACTIVE) & ~buf_empty & ram_gnt;
    assign head_err  = buf_head[WORD_WIDTH];
    assign head_data = buf_head[WORD_WIDTH-1:0];

    m14k_fill_skid_buf #(
        .WIDTH (WORD_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .greset    (greset),
        .push      (buf_push),
        .push_data ({fd_err, fd_data}),
        .pop       (wr_fire),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign req_ready    = (state == IDLE);
    assign fill_busy    = (state != IDLE);
    assign fd_ready     = (buf_count < 2'd2);
    assign ram_wr_str   = wr_fire;
    assign ram_line_idx = wr_fire ? {set_q, word_q} : '0;
    assign ram_wr_data  = wr_fire ? head_data : '0;

    // Byte mask: full word enable in the latched way's column, zero elsewhere.
    always_comb begin
        ram_wr_mask = '0;
        for (int w = 0; w < ASSOC; w++) begin
            ram_wr_mask[w*BYTES_PER_WORD +: BYTES_PER_WORD] = {BYTES_PER_WORD{wr_fire & way_q[w]}};
        end
    end

    // Fill sequencer: latch request, count written words, flag completion.
    always_ff @(posedge clk or posedge greset) begin
        if (greset) begin
            state     <= IDLE;
            set_q     <= '0;
            way_q     <= '0;
            word_q    <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            fill_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state  <= ACTIVE;
                        set_q  <= req_set;
                        way_q  <= way_sel;
                        word_q <= start_word;
                        cnt_q  <= '0;
                        err_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (wr_fire) begin
                        word_q <= word_q + 1'b1;
                        cnt_q  <= cnt_q + 1'b1;
                        err_q  <= err_q | head_err;
                        if (cnt_q == LAST_CNT) begin
                            state     <= CMPL;
                            fill_done <= 1'b1;
                            fill_err  <= err_q | head_err;
                        end
                    end
                end
                CMPL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m14k_dcache_fill_writer.sv
// Bench for m14k_dcache_fill_writer: a directed vector table for the basic
// fill, hand-written multi-cycle scenarios, and randomized fills checked
// against a queue-based reference model.
module tb_m14k_dcache_fill_writer;

    localparam int LIS = 10;
    localparam int WW  = 32;

    logic           clk = 1'b0;
    logic           greset;
    logic           req_valid;
    logic           req_ready;
    logic [7:0]     req_set;
    logic [1:0]     req_way;
    logic [1:0]     req_crit;
    logic           fd_valid;
    logic           fd_ready;
    logic [WW-1:0]  fd_data;
    logic           fd_err;
    logic           ram_gnt;
    logic [LIS-1:0] ram_line_idx;
    logic [7:0]     ram_wr_mask;
    logic           ram_wr_str;
    logic [WW-1:0]  ram_wr_data;
    logic           fill_busy;
    logic           fill_done;
    logic           fill_err;

    always #5 clk = ~clk;

    m14k_dcache_fill_writer #(
        .ASSOC(2), .LINE_IDX_SIZE(LIS), .WORD_WIDTH(WW), .BYTES_PER_WORD(4)
    ) dut (
        .clk(clk), .greset(greset),
        .req_valid(req_valid), .req_ready(req_ready), .req_set(req_set),
        .req_way(req_way), .req_crit(req_crit),
        .fd_valid(fd_valid), .fd_ready(fd_ready), .fd_data(fd_data), .fd_err(fd_err),
        .ram_gnt(ram_gnt), .ram_line_idx(ram_line_idx), .ram_wr_mask(ram_wr_mask),
        .ram_wr_str(ram_wr_str), .ram_wr_data(ram_wr_data),
        .fill_busy(fill_busy), .fill_done(fill_done), .fill_err(fill_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered words plus fill progress.
    typedef struct { logic [WW-1:0] data; logic err; } word_t;
    word_t      q[$];
    int         phase;      // 0 waiting, 1 filling, 2 completion cycle
    int         m_k;        // words written in current fill
    logic       m_err;
    logic [7:0] m_set;
    logic [1:0] m_way;
    logic [1:0] m_crit;

    logic [9:0] rows[$];
    int         stall_cnt;
    logic       last_err;

    typedef struct {
        logic rv; logic fv; logic [WW-1:0] d; logic g;
        logic e_rr; logic e_fr; logic e_busy; logic e_wr;
        logic [9:0] e_idx; logic [7:0] e_mask; logic [WW-1:0] e_data;
        logic e_done; logic e_err;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int way_col(input logic [1:0] w);
        return w[1] ? 1 : 0;
    endfunction

    function automatic logic [1:0] start_of(input logic [1:0] c);
`ifdef M14K_FILL_CRITWORD_EN
        return c;
`else
        return 2'd0;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        phase = 0;
        m_k   = 0;
        m_err = 1'b0;
    endtask

    // One clock cycle: drive at posedge+1, sample at posedge+2, advance model.
    task automatic cycle(input logic rv, input logic [7:0] s, input logic [1:0] w,
                         input logic [1:0] c, input logic fv, input logic [WW-1:0] d,
                         input logic e, input logic g,
                         output logic acc, output logic wr, output logic dn);
        logic exp_wr;
        int   sz;
        int   row;
        req_valid = rv; req_set = s; req_way = w; req_crit = c;
        fd_valid = fv; fd_data = d; fd_err = e; ram_gnt = g;
        #1;
        sz     = q.size();
        exp_wr = (phase == 1) && (sz > 0) && g;
        chk("req_ready", req_ready, phase == 0);
        chk("fd_ready", fd_ready, sz < 2);
        chk("fill_busy", fill_busy, phase != 0);
        chk("ram_wr_str", ram_wr_str, exp_wr);
        chk("fill_done", fill_done, phase == 2);
        if (phase == 2) chk("fill_err", fill_err, m_err);
        if (exp_wr) begin
            row = int'(m_set) * 4 + ((int'(start_of(m_crit)) + m_k) % 4);
            chk("ram_line_idx", ram_line_idx, 64'(row));
            chk("ram_wr_mask", ram_wr_mask, 64'(32'hF << (4 * way_col(m_way))));
            chk("ram_wr_data", ram_wr_data, q[0].data);
        end
        if (ram_wr_str) rows.push_back(ram_line_idx);
        if (fill_done) last_err = fill_err;
        if (fv && !fd_ready) stall_cnt++;
        acc = fv && (sz < 2);
        wr  = exp_wr;
        dn  = (phase == 2);
        if (exp_wr) begin
            m_err = m_err | q[0].err;
            void'(q.pop_front());
            m_k++;
            if (m_k == 4) phase = 2;
        end else if (phase == 2) begin
            phase = 0;
        end else if (phase == 0 && rv) begin
            phase = 1; m_k = 0; m_err = 1'b0;
            m_set = s; m_way = w; m_crit = c;
        end
        if (acc) q.push_back('{data: d, err: e});
        @(posedge clk);
        #1;
    endtask

    // Full fill: request, then send 4 words; gnt from gnt_lo bitmap or random.
    task automatic run_seq(input logic [7:0] s, input logic [1:0] w, input logic [1:0] c,
                           input int err_word, input logic [31:0] gnt_lo,
                           input bit rnd, input bit hold_req, output int nwr);
        int   sent = 0;
        int   cyc  = 0;
        bit   got  = 0;
        bit   fin  = 0;
        bit   was_idle;
        logic acc, wr, dn, rv, fv, g, e;
        logic [WW-1:0] d;
        nwr = 0;
        while (!fin && cyc < 200) begin
            rv = !got || hold_req;
            fv = got && (sent < 4) && (!rnd || $urandom_range(0, 3) != 0);
            d  = rnd ? WW'($urandom) : (32'hA000_0000 | (32'(s) << 8) | 32'(sent));
            e  = (sent == err_word) || (rnd && $urandom_range(0, 7) == 0);
            g  = rnd ? ($urandom_range(0, 3) != 0) : !(cyc < 32 && gnt_lo[cyc]);
            was_idle = (phase == 0);
            cycle(rv, got ? ~s : s, w, c, fv, d, e, g, acc, wr, dn);
            if (was_idle && rv) got = 1;
            if (acc) sent++;
            if (wr) nwr++;
            if (dn) fin = 1;
            cyc++;
        end
        chk("fill_completes", fin, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nwr;
        logic       acc, wr, dn;
        logic [9:0] exp_rows[4];
        int         wcount;
        int         ndone;
        int         sent;

        tv[0] = '{1, 0, 32'h0,         1, 1, 1, 0, 0, 10'h000, 8'h00, 32'h0,         0, 0};
        tv[1] = '{0, 1, 32'hDEAD_00A0, 1, 0, 1, 1, 0, 10'h000, 8'h00, 32'h0,         0, 0};
        tv[2] = '{0, 1, 32'hDEAD_00A1, 1, 0, 1, 1, 1, 10'h168, 8'hF0, 32'hDEAD_00A0, 0, 0};
        tv[3] = '{0, 1, 32'hDEAD_00A2, 1, 0, 1, 1, 1, 10'h169, 8'hF0, 32'hDEAD_00A1, 0, 0};
        tv[4] = '{0, 1, 32'hDEAD_00A3, 1, 0, 1, 1, 1, 10'h16A, 8'hF0, 32'hDEAD_00A2, 0, 0};
        tv[5] = '{0, 0, 32'h0,         1, 0, 1, 1, 1, 10'h16B, 8'hF0, 32'hDEAD_00A3, 0, 0};
        tv[6] = '{0, 0, 32'h0,         1, 0, 1, 1, 0, 10'h000, 8'h00, 32'h0,         1, 0};
        tv[7] = '{0, 0, 32'h0,         1, 1, 1, 0, 0, 10'h000, 8'h00, 32'h0,         0, 0};

        greset = 1'b1;
        req_valid = 0; req_set = 0; req_way = 0; req_crit = 0;
        fd_valid = 0; fd_data = 0; fd_err = 0; ram_gnt = 0;
        stall_cnt = 0; last_err = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_fd_ready", fd_ready, 1'b1);
        chk("rst_wr_str", ram_wr_str, 1'b0);
        chk("rst_busy", fill_busy, 1'b0);
        chk("rst_done", fill_done, 1'b0);
        chk("rst_err", fill_err, 1'b0);
        chk("rst_idx", ram_line_idx, 10'h0);
        chk("rst_mask", ram_wr_mask, 8'h0);
        chk("rst_data", ram_wr_data, 32'h0);
        greset = 1'b0;

        // Basic fill, set 0x5A way 1, words in order, grant always high.
        for (int i = 0; i < 8; i++) begin
            req_valid = tv[i].rv; req_set = 8'h5A; req_way = 2'b10; req_crit = 2'd0;
            fd_valid = tv[i].fv; fd_data = tv[i].d; fd_err = 1'b0; ram_gnt = tv[i].g;
            #1;
            chk("tv_req_ready", req_ready, tv[i].e_rr);
            chk("tv_fd_ready", fd_ready, tv[i].e_fr);
            chk("tv_busy", fill_busy, tv[i].e_busy);
            chk("tv_wr_str", ram_wr_str, tv[i].e_wr);
            chk("tv_done", fill_done, tv[i].e_done);
            if (tv[i].e_done) chk("tv_err", fill_err, tv[i].e_err);
            if (tv[i].e_wr) begin
                chk("tv_idx", ram_line_idx, tv[i].e_idx);
                chk("tv_mask", ram_wr_mask, tv[i].e_mask);
                chk("tv_data", ram_wr_data, tv[i].e_data);
            end
            @(posedge clk);
            #1;
        end
        model_reset();

        // Critical-word start (order depends on build option), way 0.
        rows.delete();
`ifdef M14K_FILL_CRITWORD_EN
        exp_rows[0] = 10'h0CE; exp_rows[1] = 10'h0CF; exp_rows[2] = 10'h0CC; exp_rows[3] = 10'h0CD;
`else
        exp_rows[0] = 10'h0CC; exp_rows[1] = 10'h0CD; exp_rows[2] = 10'h0CE; exp_rows[3] = 10'h0CF;
`endif
        run_seq(8'h33, 2'b01, 2'd2, -1, 32'h0, 0, 0, nwr);
        chk("crit_rows_count", rows.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < rows.size()) chk("crit_row", rows[i], exp_rows[i]);
        end

        // Grant withheld for three cycles mid-fill: buffer fills, fd_ready drops.
        stall_cnt = 0;
        run_seq(8'h12, 2'b10, 2'd0, -1, 32'h0000_0038, 0, 0, nwr);
        chk("gnt_stall_fd_ready_low", stall_cnt > 0, 1'b1);
        chk("gnt_stall_writes", nwr, 4);

        // Bus error on word 1: still four writes, fill_err set; next fill clean.
        last_err = 1'b0;
        run_seq(8'h77, 2'b01, 2'd1, 1, 32'h0, 0, 0, nwr);
        chk("err_writes", nwr, 4);
        chk("err_flag", last_err, 1'b1);
        run_seq(8'h78, 2'b01, 2'd0, -1, 32'h0, 0, 0, nwr);
        chk("err_cleared", last_err, 1'b0);

        // Back-to-back: request held through the first fill with a different set.
        run_seq(8'h40, 2'b10, 2'd3, -1, 32'h0, 0, 1, nwr);
        run_seq(8'h41, 2'b01, 2'd1, -1, 32'h0, 0, 0, nwr);
        chk("b2b_second_writes", nwr, 4);

        // Reset after two words written.
        cycle(1, 8'h2C, 2'b10, 2'd0, 0, 32'h0, 0, 1, acc, wr, dn);
        wcount = 0; sent = 0;
        for (int n = 0; n < 20 && wcount < 2; n++) begin
            cycle(0, 8'h2C, 2'b10, 2'd0, sent < 4, 32'hBEEF_0000 | 32'(sent), 0, 1, acc, wr, dn);
            if (acc) sent++;
            if (wr) wcount++;
        end
        chk("rstmid_setup", wcount, 2);
        greset = 1'b1;
        #1;
        chk("rstmid_wr_str", ram_wr_str, 1'b0);
        chk("rstmid_req_ready", req_ready, 1'b1);
        chk("rstmid_fd_ready", fd_ready, 1'b1);
        chk("rstmid_busy", fill_busy, 1'b0);
        @(posedge clk);
        #1;
        greset = 1'b0;
        model_reset();
        wcount = 0; ndone = 0;
        for (int n = 0; n < 6; n++) begin
            cycle(0, 8'h2C, 2'b10, 2'd0, 0, 32'h0, 0, 1, acc, wr, dn);
            if (ram_wr_str) wcount++;
            if (fill_done) ndone++;
        end
        chk("rstmid_no_strobe", wcount, 0);
        chk("rstmid_no_done", ndone, 0);

        // Randomized fills against the model.
        for (int i = 0; i < 25; i++) begin
            run_seq(8'($urandom), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01,
                    2'($urandom_range(0, 3)), -1, 32'h0, 1, ($urandom_range(0, 3) == 0), nwr);
            chk("rnd_writes", nwr, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
